ahb3lite_master: RTL and testbench

Single-initiator AHB3-Lite manager that turns a simple command/response stream into pipelined AHB3-Lite SINGLE transfers. It sits between on-chip control logic (or a bench sequencer) and one AHB3-Lite subordinate such as the SRAM slave, driving HSEL/HADDR/HTRANS/HWDATA and collecting HRDATA/HRESP. Address and data phases overlap, so back-to-back commands sustain one transfer per cycle with a zero-wait subordinate.

---
 rtl/ahb3lite_master.sv | 167 ++++++++++++++++
 tb/tb_ahb3lite_master.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_master.sv
`default_nettype none
// ============================================================================
//  Module   : ahb3lite_master
//  Purpose  : Single-initiator AHB3-Lite manager. Converts a simple
//             command/response stream into pipelined AHB3-Lite SINGLE
//             transfers with overlapped address and data phases.
//  Ports    : HCLK/HRESET          clock, synchronous active-high reset
//             cmd_*                command stream (valid/ready handshake)
//             rsp_*                one-cycle response pulse per command
//             H* outputs           AHB3-Lite manager signals
//             HREADYOUT/HRESP/HRDATA subordinate response
//  Revision : 1.0  initial release
// ============================================================================
module ahb3lite_master #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  // command stream
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [HADDR_SIZE-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_size,
  input  logic [HDATA_SIZE-1:0] cmd_wdata,
  // response stream
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [HDATA_SIZE-1:0] rsp_rdata,
  output logic                  rsp_error,
  // AHB3-Lite manager
  output logic                  HSEL,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic [HDATA_SIZE-1:0] HWDATA,
  output logic                  HREADY,
  input  logic                  HREADYOUT,
  input  logic                  HRESP,
  input  logic [HDATA_SIZE-1:0] HRDATA
);

  localparam logic [2:0] MAXSIZE      = 3'($clog2(HDATA_SIZE / 8));
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  // Address-phase stage (A)
  logic                  a_valid_q, a_valid_d;
  logic [HADDR_SIZE-1:0] a_addr_q,  a_addr_d;
  logic                  a_write_q, a_write_d;
  logic [2:0]            a_size_q,  a_size_d;
  logic [HDATA_SIZE-1:0] a_wdata_q, a_wdata_d;
  // Data-phase stage (D)
  logic                  d_valid_q, d_valid_d;
  logic                  d_write_q, d_write_d;
  logic [HDATA_SIZE-1:0] d_wdata_q, d_wdata_d;
  // Response register
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [HDATA_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_error_q, rsp_error_d;

  logic                  a_advance;
  logic                  d_retire;
  logic                  cmd_fire;
  logic [2:0]            size_clamped;
  logic [HADDR_SIZE-1:0] addr_aligned;

  // A only moves forward on an OKAY completion; during an ERROR response the
  // pending command stays in A and is reissued once the error has finished.
  assign a_advance = a_valid_q & HREADYOUT & ~HRESP;
  assign d_retire  = d_valid_q & HREADYOUT;
  assign cmd_ready = ~HRESET & (~a_valid_q | (HREADYOUT & ~HRESP));
  assign cmd_fire  = cmd_valid & cmd_ready;

  // Clamp the transfer size to the bus width, then align the address to it.
  assign size_clamped = (cmd_size > MAXSIZE) ? MAXSIZE : cmd_size;
  assign addr_aligned = cmd_addr &
                        ~((HADDR_SIZE'(1) << size_clamped) - HADDR_SIZE'(1));

  always_comb begin
    a_valid_d   = a_valid_q;
    a_addr_d    = a_addr_q;
    a_write_d   = a_write_q;
    a_size_d    = a_size_q;
    a_wdata_d   = a_wdata_q;
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    d_wdata_d   = d_wdata_q;

    // D either takes the command leaving A, or empties when it retires alone.
    if (a_advance) begin
      d_valid_d = 1'b1;
      d_write_d = a_write_q;
      d_wdata_d = a_wdata_q;
      a_valid_d = 1'b0;
    end else if (d_retire) begin
      d_valid_d = 1'b0;
    end

    // cmd_fire implies A is empty or is advancing this edge.
    if (cmd_fire) begin
      a_valid_d = 1'b1;
      a_addr_d  = addr_aligned;
      a_write_d = cmd_write;
      a_size_d  = size_clamped;
      a_wdata_d = cmd_wdata;
    end

    rsp_valid_d = d_retire;
    rsp_write_d = d_retire & d_write_q;
    rsp_error_d = d_retire & HRESP;
    rsp_rdata_d = (d_retire & ~d_write_q) ? HRDATA : '0;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_valid_q   <= 1'b0;
      a_addr_q    <= '0;
      a_write_q   <= 1'b0;
      a_size_q    <= 3'd0;
      a_wdata_q   <= '0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      d_wdata_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_addr_q    <= a_addr_d;
      a_write_q   <= a_write_d;
      a_size_q    <= a_size_d;
      a_wdata_q   <= a_wdata_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      d_wdata_q   <= d_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  assign HSEL      = a_valid_q;
  assign HADDR     = a_addr_q;
  assign HWRITE    = a_write_q;
  assign HSIZE     = a_size_q;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  // Both ERROR cycles must show IDLE so the held command is not issued early.
  assign HTRANS    = (a_valid_q & ~HRESP) ? TRANS_NONSEQ : TRANS_IDLE;
  assign HWDATA    = d_wdata_q;
  assign HREADY    = HREADYOUT;

  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb3lite_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb3lite_master
//  Purpose  : Self-checking bench for ahb3lite_master with a small word-wide
//             AHB3-Lite subordinate model; the bench drives HREADYOUT/HRESP
//             directly for wait-state and error sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ahb3lite_master;

  logic        HCLK;
  logic        HRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  // 16-bit instance for the size clamp check
  logic        cmd_valid16;
  logic        cmd_ready16;
  logic [15:0] cmd_wdata16;
  logic        rsp_valid16;
  logic        rsp_write16;
  logic [15:0] rsp_rdata16;
  logic        rsp_error16;
  logic        HSEL16;
  logic [31:0] HADDR16;
  logic        HWRITE16;
  logic [2:0]  HSIZE16;
  logic [2:0]  HBURST16;
  logic [3:0]  HPROT16;
  logic [1:0]  HTRANS16;
  logic [15:0] HWDATA16;
  logic        HREADY16;

  ahb3lite_master #(.HADDR_SIZE(32), .HDATA_SIZE(32)) u_dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  ahb3lite_master #(.HADDR_SIZE(32), .HDATA_SIZE(16)) u_dut16 (
    .HCLK(HCLK), .HRESET(HRESET),
    .cmd_valid(cmd_valid16), .cmd_ready(cmd_ready16), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata16),
    .rsp_valid(rsp_valid16), .rsp_write(rsp_write16), .rsp_rdata(rsp_rdata16),
    .rsp_error(rsp_error16),
    .HSEL(HSEL16), .HADDR(HADDR16), .HWRITE(HWRITE16), .HSIZE(HSIZE16),
    .HBURST(HBURST16), .HPROT(HPROT16), .HTRANS(HTRANS16), .HWDATA(HWDATA16),
    .HREADY(HREADY16), .HREADYOUT(1'b1), .HRESP(1'b0), .HRDATA(16'h0000)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // ---------------- subordinate model (word-wide memory) ----------------
  logic [31:0] mem [0:63];
  logic        mem_clr;
  logic        dp_valid;
  logic        dp_write;
  logic [31:0] dp_addr;

  always @(posedge HCLK) begin
    if (mem_clr) begin
      for (int k = 0; k < 64; k++) mem[k] <= 32'hC0DE_0000 | 32'(k);
    end else if (HREADYOUT && !HRESP && dp_valid && dp_write) begin
      mem[dp_addr[7:2]] <= HWDATA;
    end
    if (HREADYOUT) begin
      dp_valid <= HSEL && (HTRANS == 2'b10);
      dp_addr  <= HADDR;
      dp_write <= HWRITE;
    end
  end

  assign HRDATA = (dp_valid && !dp_write) ? mem[dp_addr[7:2]] : 32'h0;

  // ---------------- checking ----------------
  int n_vec;
  int n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #2;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_haddr;
    logic [2:0]  exp_hsize;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] b2b_data [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    vecs[0] = '{1'b1, 32'h1C, 3'd2, 32'h0000_0159, 32'h1C, 3'd2, 32'h0};
    vecs[1] = '{1'b0, 32'h1C, 3'd2, 32'h0,         32'h1C, 3'd2, 32'h0000_0159};
    vecs[2] = '{1'b1, 32'h1D, 3'd2, 32'hA5A5_0001, 32'h1C, 3'd2, 32'h0};
    vecs[3] = '{1'b0, 32'h1C, 3'd2, 32'h0,         32'h1C, 3'd2, 32'hA5A5_0001};
    vecs[4] = '{1'b1, 32'h23, 3'd1, 32'h1234_0000, 32'h22, 3'd1, 32'h0};
    vecs[5] = '{1'b0, 32'h20, 3'd2, 32'h0,         32'h20, 3'd2, 32'h1234_0000};
    vecs[6] = '{1'b1, 32'h30, 3'd7, 32'hDEAD_BEEF, 32'h30, 3'd2, 32'h0};
    vecs[7] = '{1'b0, 32'h31, 3'd0, 32'h0,         32'h31, 3'd0, 32'hDEAD_BEEF};
    b2b_data[0] = 32'h1111_1111;
    b2b_data[1] = 32'h2222_2222;
    b2b_data[2] = 32'h3333_3333;
    b2b_data[3] = 32'h4444_4444;

    HRESET = 1'b1; mem_clr = 1'b1;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_size = 3'd0; cmd_wdata = '0;
    cmd_valid16 = 1'b0; cmd_wdata16 = '0;
    HREADYOUT = 1'b1; HRESP = 1'b0;

    // ---- reset state ----
    repeat (3) step();
    chk("rst_hsel",   64'(HSEL),      64'd0);
    chk("rst_htrans", 64'(HTRANS),    64'd0);
    chk("rst_haddr",  64'(HADDR),     64'd0);
    chk("rst_hwdata", 64'(HWDATA),    64'd0);
    chk("rst_rspv",   64'(rsp_valid), 64'd0);
    chk("rst_ready",  64'(cmd_ready), 64'd0);
    chk("rst_hprot",  64'(HPROT),     64'h3);
    HRESET = 1'b0; mem_clr = 1'b0;
    step();

    // ---- table-driven single commands, zero-wait ----
    for (int i = 0; i < 8; i++) begin
      cmd_write = vecs[i].wr; cmd_addr = vecs[i].addr;
      cmd_size = vecs[i].size; cmd_wdata = vecs[i].wdata; cmd_valid = 1'b1;
      #1;
      chk("tbl_ready", 64'(cmd_ready), 64'd1);
      step();
      cmd_valid = 1'b0;
      chk("tbl_htrans", 64'(HTRANS), 64'h2);
      chk("tbl_haddr",  64'(HADDR),  64'(vecs[i].exp_haddr));
      chk("tbl_hsize",  64'(HSIZE),  64'(vecs[i].exp_hsize));
      chk("tbl_hwrite", 64'(HWRITE), 64'(vecs[i].wr));
      step();
      if (vecs[i].wr) chk("tbl_hwdata", 64'(HWDATA), 64'(vecs[i].wdata));
      chk("tbl_rspv_early", 64'(rsp_valid), 64'd0);
      step();
      chk("tbl_rspv",   64'(rsp_valid), 64'd1);
      chk("tbl_rspw",   64'(rsp_write), 64'(vecs[i].wr));
      chk("tbl_rdata",  64'(rsp_rdata), 64'(vecs[i].exp_rdata));
      chk("tbl_rsperr", 64'(rsp_error), 64'd0);
      step();
      chk("tbl_rspv_late", 64'(rsp_valid), 64'd0);
    end

    // ---- back-to-back: 4 writes then 4 reads ----
    cmd_write = 1'b1; cmd_addr = 32'h0; cmd_size = 3'd2; cmd_wdata = b2b_data[0];
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i < 8) begin
        chk("b2b_htrans", 64'(HTRANS), 64'h2);
        chk("b2b_haddr",  64'(HADDR),  64'((i % 4) * 4));
        chk("b2b_hwrite", 64'(HWRITE), 64'(i < 4));
      end
      if (i >= 2) begin
        chk("b2b_rspv", 64'(rsp_valid), 64'd1);
        chk("b2b_rspw", 64'(rsp_write), 64'((i - 2) < 4));
        if (i - 2 >= 4) chk("b2b_rdata", 64'(rsp_rdata), 64'(b2b_data[i - 6]));
      end else begin
        chk("b2b_rspv_early", 64'(rsp_valid), 64'd0);
      end
      if (i + 1 < 8) begin
        cmd_write = (i + 1) < 4;
        cmd_addr  = 32'(((i + 1) % 4) * 4);
        cmd_wdata = ((i + 1) < 4) ? b2b_data[i + 1] : 32'h0;
      end else begin
        cmd_valid = 1'b0;
      end
    end
    step();
    chk("b2b_rspv_end", 64'(rsp_valid), 64'd0);

    // ---- wait states: 3 cycles in a read data phase ----
    cmd_write = 1'b0; cmd_addr = 32'h0; cmd_size = 3'd2; cmd_wdata = 32'h0; cmd_valid = 1'b1;
    step();
    chk("ws_haddr0", 64'(HADDR), 64'h0);
    cmd_addr = 32'h4;
    step();
    cmd_addr = 32'h8; HREADYOUT = 1'b0;
    #1;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) step();
      chk("ws_ready",  64'(cmd_ready), 64'd0);
      chk("ws_htrans", 64'(HTRANS),    64'h2);
      chk("ws_haddr",  64'(HADDR),     64'h4);
      chk("ws_rspv",   64'(rsp_valid), 64'd0);
    end
    step();
    HREADYOUT = 1'b1;
    #1;
    chk("ws_rspv4",  64'(rsp_valid), 64'd0);
    chk("ws_ready4", 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    chk("ws_rspv5",  64'(rsp_valid), 64'd1);
    chk("ws_rdata5", 64'(rsp_rdata), 64'h1111_1111);
    chk("ws_haddr5", 64'(HADDR),     64'h8);
    step();
    chk("ws_rspv6",  64'(rsp_valid), 64'd1);
    chk("ws_rdata6", 64'(rsp_rdata), 64'h2222_2222);
    step();
    chk("ws_rspv7",  64'(rsp_valid), 64'd1);
    chk("ws_rdata7", 64'(rsp_rdata), 64'h3333_3333);
    step();
    chk("ws_rspv8",  64'(rsp_valid), 64'd0);

    // ---- error on write 0x40 with read 0x44 pending ----
    cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h5555_AAAA; cmd_valid = 1'b1;
    step();
    chk("err_htrans0", 64'(HTRANS), 64'h2);
    cmd_write = 1'b0; cmd_addr = 32'h44; cmd_wdata = 32'h0;
    step();
    cmd_valid = 1'b0; HREADYOUT = 1'b0; HRESP = 1'b1;
    #1;
    chk("err_htrans1", 64'(HTRANS),    64'h0);
    chk("err_ready1",  64'(cmd_ready), 64'd0);
    step();
    HREADYOUT = 1'b1;
    #1;
    chk("err_htrans2", 64'(HTRANS),    64'h0);
    chk("err_haddr2",  64'(HADDR),     64'h44);
    chk("err_rspv2",   64'(rsp_valid), 64'd0);
    step();
    HRESP = 1'b0;
    #1;
    chk("err_rspv3",   64'(rsp_valid), 64'd1);
    chk("err_rsperr3", 64'(rsp_error), 64'd1);
    chk("err_rspw3",   64'(rsp_write), 64'd1);
    chk("err_htrans3", 64'(HTRANS),    64'h2);
    chk("err_haddr3",  64'(HADDR),     64'h44);
    step();
    chk("err_rspv4",   64'(rsp_valid), 64'd0);
    step();
    chk("err_rspv5",   64'(rsp_valid), 64'd1);
    chk("err_rsperr5", 64'(rsp_error), 64'd0);
    chk("err_rdata5",  64'(rsp_rdata), 64'hC0DE_0011);

    // ---- reset during a data phase ----
    cmd_write = 1'b1; cmd_addr = 32'h50; cmd_wdata = 32'h0000_0077; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    chk("mr_hwdata", 64'(HWDATA), 64'h77);
    HRESET = 1'b1;
    step();
    chk("mr_rspv",   64'(rsp_valid), 64'd0);
    chk("mr_hsel",   64'(HSEL),      64'd0);
    chk("mr_htrans", 64'(HTRANS),    64'h0);
    chk("mr_haddr",  64'(HADDR),     64'h0);
    chk("mr_hwdata0",64'(HWDATA),    64'h0);
    chk("mr_ready",  64'(cmd_ready), 64'd0);
    HRESET = 1'b0;
    step();
    chk("mr_rspv1",  64'(rsp_valid), 64'd0);
    cmd_write = 1'b0; cmd_addr = 32'h1C; cmd_wdata = 32'h0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("mr_htrans1", 64'(HTRANS), 64'h2);
    chk("mr_haddr1",  64'(HADDR),  64'h1C);
    step();
    step();
    chk("mr_rspv2",  64'(rsp_valid), 64'd1);
    chk("mr_rdata2", 64'(rsp_rdata), 64'hA5A5_0001);

    // ---- 16-bit bus: size 2 clamps to 1, address aligned to halfword ----
    cmd_write = 1'b1; cmd_addr = 32'h1F; cmd_size = 3'd2; cmd_wdata16 = 16'hBEEF;
    cmd_valid16 = 1'b1;
    step();
    cmd_valid16 = 1'b0;
    chk("w16_hsize",  64'(HSIZE16),  64'd1);
    chk("w16_haddr",  64'(HADDR16),  64'h1E);
    chk("w16_htrans", 64'(HTRANS16), 64'h2);
    step();
    chk("w16_hwdata", 64'(HWDATA16), 64'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
